irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Priority interrupt controller for the Hazard2 SoC. Collects interrupt requests from the GPIO, UART and I2S peripherals and resolves them by fixed priority. Drives a single interrupt line to the CPU and exposes a claim/complete register handshake. It sits between the peripheral IRQ outputs and the core's external-interrupt input, with its registers mapped on the peripheral bus.

## Interface
- NUM_SRC, 8, number of interrupt sources, 1..31; source i has ID i+1, and ID 0 means none
- SYNC_STAGES, 2, synchronizer depth per source, 2..3
- HCLK  in  1  system clock, rising-edge active
- HRESET  in  1  asynchronous, active-high reset
- irq_src  in  NUM_SRC  raw interrupt requests, asynchronous to HCLK
- reg_sel  in  1  register access strobe, one cycle per access
- reg_we  in  1  1 = write, 0 = read
- reg_addr  in  3  word offset
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, registered
- irq_out  out  1  interrupt request to the CPU, registered

## Operation
Register map (word offsets):
- 0 PENDING: read; write-1-to-clear, edge-mode bits only
- 1 ENABLE: read/write
- 2 EDGE: read/write; 1 = rising-edge, 0 = level
- 3 CLAIM: read returns the winning ID, or 0 if none
- 4 COMPLETE: write an ID
- 5 STATUS: read; [1:0] = state, [12:8] = in-service ID

Pending bits:
- Level mode: the pending bit equals the synchronized level and is not writable.
- Edge mode: the pending bit sets on a 0→1 transition of the synchronized signal and holds until claimed or W1C.

Priority and arbitration:
- Winner = lowest-index source with pending&enable set.
- Arbitration uses registered pending and enable.

State machine:
- IDLE: irq_out=0. Moves to ASSERT when any pending&enable bit is set.
- ASSERT: irq_out=1.
  - If pending&enable becomes 0 (disable, or W1C), return to IDLE.
  - A CLAIM read returning a non-zero ID moves to INSVC and latches that ID. If the source is edge-mode, the claim also clears its pending bit.
- INSVC: irq_out=0, no nesting.
  - A COMPLETE write whose ID equals the latched ID moves to IDLE.
  - A COMPLETE write with any other ID is ignored.
- CLAIM read with no winner, or read in INSVC: returns 0 with no side effects. An INSVC read does not return the latched ID.

Boundary cases:
- New edges during INSVC set their pending bits and are serviced after COMPLETE.
- Level source still high at COMPLETE: re-asserts through IDLE→ASSERT.
- Edge set and W1C on the same bit in the same cycle: set wins.
- Edge set and claim-clear on the same bit in the same cycle: set wins, so the bit stays pending.
- Writes to read-only offsets and unmapped offsets are ignored; reads of them return 0.
- Bits at positions ≥ NUM_SRC read 0.

## Timing
- Reset values: all registers 0, synchronizer flops 0, state IDLE, irq_out 0, reg_rdata 0.
- Reset is honored mid-operation, discarding pending and in-service state.
- An edge-mode source already high at reset release counts as one edge.
- Source latency: irq_src first sampled high at edge N gives a synchronized high at edge N+SYNC_STAGES-1. The pending bit sets at edge N+SYNC_STAGES, and irq_out is high after edge N+SYNC_STAGES+1 (default: 4 edges).
- Read: reg_rdata is valid the cycle after the reg_sel read cycle and holds until the next read.
- CLAIM side effects take effect at the end of the access cycle: irq_out is low the next cycle.
- Write: takes effect at the end of the access cycle.
- COMPLETE → IDLE takes one cycle. irq_out can re-assert one cycle later, so minimum low time after COMPLETE is 2 cycles.
- ENABLE cleared while in ASSERT: irq_out drops 2 cycles after the write cycle.

## Structure
- Package irq_pkg holds:
  - register offset constants
  - the state enum (IDLE=0, ASSERT=1, INSVC=2)
  - the ID width constant (5)
- Sub-module irq_sync_edge holds one source's synchronizer chain plus its previous-value flop. It outputs the level and a rise pulse and is instantiated NUM_SRC times.
- The top level holds the pending, enable and edge registers, the priority encoder, the FSM and the register decode.

## Test plan
- Reset: ENABLE=0xFF, EDGE=0x00, irq_src=0x04 → irq_out=1 4 edges after sampling; CLAIM reads 3; STATUS reads in-service ID 3 with state 2; irq_out=0 next cycle.
- Priority: EDGE=0xFF, pulse sources 5 and 1 in the same cycle. CLAIM returns 2, then COMPLETE 2. CLAIM returns 6. PENDING reads 0 afterward.
- Complete mismatch: in INSVC on ID 3, write COMPLETE 4 → state stays INSVC. Write COMPLETE 3 → IDLE; the level source is still high, so irq_out=1 after 2 cycles.
- Edge during service: claim ID 1 (edge mode). Pulse source 0 again during INSVC → PENDING bit 0 set, irq_out stays 0. After COMPLETE 1, irq_out=1 and CLAIM returns 1.
- W1C collision: W1C bit 2 in the same cycle as a new edge on source 2 → PENDING bit 2 reads 1. A W1C with no edge → reads 0, and irq_out returns to 0.
- Reset mid-operation: assert HRESET while in INSVC → irq_out=0 and all registers 0 immediately. After release with edge-mode source 0 held high, PENDING bit 0 sets.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the Hazard2 priority interrupt controller:
// register word offsets, FSM state encoding and the interrupt-ID width.
package irq_pkg;

   localparam int unsigned ID_W = 5;

   localparam logic [2:0] OFF_PENDING  = 3'd0;
   localparam logic [2:0] OFF_ENABLE   = 3'd1;
   localparam logic [2:0] OFF_EDGE     = 3'd2;
   localparam logic [2:0] OFF_CLAIM    = 3'd3;
   localparam logic [2:0] OFF_COMPLETE = 3'd4;
   localparam logic [2:0] OFF_STATUS   = 3'd5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      INSVC  = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source: multi-flop synchronizer into the HCLK domain plus a
// previous-value flop, giving the synchronized level and a one-cycle rise pulse.
module irq_sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic [STAGES-1:0] r_chain;
   logic              r_prev;

   // r_prev resets low so a source already high at reset release yields one rise
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_chain <= '0;
         r_prev  <= 1'b0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_async};
         r_prev  <= r_chain[STAGES-1];
      end
   end

   assign o_level = r_chain[STAGES-1];
   assign o_rise  = o_level & ~r_prev;

endmodule

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt controller: pending/enable/edge registers, lowest-index
// arbitration, claim/complete FSM driving a single registered CPU interrupt line.
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int unsigned NUM_SRC     = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               HCLK,
   input  logic               HRESET,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               reg_sel,
   input  logic               reg_we,
   input  logic [2:0]         reg_addr,
   input  logic [31:0]        reg_wdata,
   output logic [31:0]        reg_rdata,
   output logic               irq_out
);

   logic [NUM_SRC-1:0] w_level, w_rise, w_pe, w_win_oh, w_w1c, w_clr, w_pend_nxt;
   logic [NUM_SRC-1:0] r_pending, r_enable, r_edge;
   logic [ID_W-1:0]    w_win_id, r_insvc_id;
   logic [31:0]        r_rdata;
   logic               r_irq;
   logic               w_rd, w_wr, w_claim, w_complete;
   irq_state_e         r_state;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
      irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
         .i_clk   (HCLK),
         .i_rst   (HRESET),
         .i_async (irq_src[g]),
         .o_level (w_level[g]),
         .o_rise  (w_rise[g])
      );
   end

   assign w_pe = r_pending & r_enable;

   // Scan from the top so the lowest pending index is the last assignment
   always_comb begin
      w_win_id = '0;
      w_win_oh = '0;
      for (int unsigned i = NUM_SRC; i > 0; i--) begin
         if (w_pe[i-1]) begin
            w_win_id      = ID_W'(i);
            w_win_oh      = '0;
            w_win_oh[i-1] = 1'b1;
         end
      end
   end

   assign w_rd       = reg_sel & ~reg_we;
   assign w_wr       = reg_sel & reg_we;
   assign w_claim    = w_rd && (reg_addr == OFF_CLAIM) && (r_state == ASSERT) && (w_win_id != '0);
   assign w_complete = w_wr && (reg_addr == OFF_COMPLETE) && (r_state == INSVC) &&
                       (reg_wdata == 32'(r_insvc_id));
   assign w_w1c      = (w_wr && (reg_addr == OFF_PENDING)) ? reg_wdata[NUM_SRC-1:0] : '0;
   assign w_clr      = w_w1c | (w_claim ? w_win_oh : '0);

   // Edge bits: a new rise beats any clear in the same cycle; level bits track the input
   assign w_pend_nxt = (r_edge & (w_rise | (r_pending & ~w_clr))) | (~r_edge & w_level);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_pending <= '0;
         r_enable  <= '0;
         r_edge    <= '0;
      end else begin
         r_pending <= w_pend_nxt;
         if (w_wr && (reg_addr == OFF_ENABLE)) r_enable <= reg_wdata[NUM_SRC-1:0];
         if (w_wr && (reg_addr == OFF_EDGE))   r_edge   <= reg_wdata[NUM_SRC-1:0];
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state    <= IDLE;
         r_irq      <= 1'b0;
         r_insvc_id <= '0;
         r_rdata    <= '0;
      end else begin
         if (w_rd) begin
            case (reg_addr)
               OFF_PENDING: r_rdata <= 32'(r_pending);
               OFF_ENABLE:  r_rdata <= 32'(r_enable);
               OFF_EDGE:    r_rdata <= 32'(r_edge);
               OFF_CLAIM:   r_rdata <= w_claim ? 32'(w_win_id) : '0;
               OFF_STATUS:  r_rdata <= {19'b0, r_insvc_id, 6'b0, r_state};
               default:     r_rdata <= '0;
            endcase
         end
         case (r_state)
            IDLE: begin
               if (w_pe != '0) begin
                  r_state <= ASSERT;
                  r_irq   <= 1'b1;
               end
            end
            ASSERT: begin
               if (w_claim) begin
                  r_state    <= INSVC;
                  r_irq      <= 1'b0;
                  r_insvc_id <= w_win_id;
               end else if (w_pe == '0) begin
                  r_state <= IDLE;
                  r_irq   <= 1'b0;
               end
            end
            INSVC: begin
               if (w_complete) begin
                  r_state    <= IDLE;
                  r_insvc_id <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_irq   <= 1'b0;
            end
         endcase
      end
   end

   assign reg_rdata = r_rdata;
   assign irq_out   = r_irq;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed plus randomized bench for irq_arbiter against a cycle-level
// behavioural model built from the register/claim/complete rules.
module tb_irq_arbiter;

   localparam int unsigned NS = 8;
   localparam int unsigned SS = 2;

   logic          HCLK = 1'b0;
   logic          HRESET = 1'b0;
   logic [NS-1:0] irq_src = '0;
   logic          reg_sel = 1'b0;
   logic          reg_we = 1'b0;
   logic [2:0]    reg_addr = '0;
   logic [31:0]   reg_wdata = '0;
   logic [31:0]   reg_rdata;
   logic          irq_out;

   int checks = 0;
   int failures = 0;

   // model state: asserted flag and in-service ID (0 = nothing in service)
   logic [NS-1:0] m_pend, m_en, m_edg;
   bit            m_irq;
   int unsigned   m_svc;
   logic [31:0]   m_rd;
   logic [NS-1:0] m_q[$];

   irq_arbiter #(.NUM_SRC(NS), .SYNC_STAGES(SS)) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .irq_src   (irq_src),
      .reg_sel   (reg_sel),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .irq_out   (irq_out)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned lowest_id(input logic [NS-1:0] v);
      int unsigned x;
      if (v == '0) return 0;
      x = 32'(v);
      return $clog2(x & (~x + 1)) + 1;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_en = '0; m_edg = '0;
      m_irq = 0; m_svc = 0; m_rd = '0;
      m_q.delete();
      repeat (SS + 1) m_q.push_back('0);
   endtask

   // One clock edge of the model, using the inputs presented for that edge
   task automatic model_step();
      logic [NS-1:0] lvl, prv, pe, clr, nxt;
      int unsigned   win;
      bit            rd, wr, claim, compl;
      pe    = m_pend & m_en;
      win   = lowest_id(pe);
      rd    = reg_sel && !reg_we;
      wr    = reg_sel && reg_we;
      claim = rd && reg_addr == 3'd3 && m_irq && win != 0;
      compl = wr && reg_addr == 3'd4 && m_svc != 0 && reg_wdata == m_svc;
      m_q.push_back(irq_src);
      lvl = m_q[1];
      prv = m_q[0];
      void'(m_q.pop_front());
      clr = (wr && reg_addr == 3'd0) ? reg_wdata[NS-1:0] : '0;
      if (claim) clr[win-1] = 1'b1;
      for (int i = 0; i < NS; i++) begin
         if (m_edg[i]) nxt[i] = (lvl[i] && !prv[i]) ? 1'b1 : (clr[i] ? 1'b0 : m_pend[i]);
         else          nxt[i] = lvl[i];
      end
      if (rd) begin
         case (reg_addr)
            3'd0:    m_rd = 32'(m_pend);
            3'd1:    m_rd = 32'(m_en);
            3'd2:    m_rd = 32'(m_edg);
            3'd3:    m_rd = claim ? win : 0;
            3'd5:    m_rd = (m_svc << 8) | (m_svc != 0 ? 2 : (m_irq ? 1 : 0));
            default: m_rd = '0;
         endcase
      end
      if (m_svc != 0) begin
         if (compl) m_svc = 0;
      end else if (m_irq) begin
         if (claim) begin
            m_svc = win;
            m_irq = 0;
         end else if (pe == '0) m_irq = 0;
      end else if (pe != '0) m_irq = 1;
      m_pend = nxt;
      if (wr && reg_addr == 3'd1) m_en  = reg_wdata[NS-1:0];
      if (wr && reg_addr == 3'd2) m_edg = reg_wdata[NS-1:0];
   endtask

   task automatic tick();
      @(posedge HCLK);
      model_step();
      #1;
      check("irq_out", 32'(irq_out), 32'(m_irq));
      check("rdata", reg_rdata, m_rd);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      reg_sel = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      tick();
      reg_sel = 1'b0; reg_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      reg_sel = 1'b1; reg_we = 1'b0; reg_addr = a;
      tick();
      reg_sel = 1'b0;
      d = reg_rdata;
   endtask

   task automatic wait_irq(input string tag);
      int n = 0;
      while (irq_out !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check(tag, 32'(irq_out), 32'd1);
   endtask

   task automatic do_reset();
      HRESET = 1'b1;
      #1;
      model_reset();
      check("rst_irq", 32'(irq_out), 32'd0);
      check("rst_rdata", reg_rdata, 32'd0);
      repeat (2) @(posedge HCLK);
      #1;
      HRESET = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      int          n;
      #2;
      do_reset();

      // reset values and level-source latency
      rd(3'd1, d); check("rst_enable", d, 32'd0);
      rd(3'd5, d); check("rst_status", d, 32'd0);
      wr(3'd1, 32'hFF);
      wr(3'd2, 32'h00);
      irq_src = 8'h04;
      n = 0;
      do begin
         tick();
         n++;
      end while (irq_out !== 1'b1 && n < 10);
      check("latency", n, 32'd4);
      rd(3'd3, d); check("claim_lvl", d, 32'd3);
      check("irq_low_after_claim", 32'(irq_out), 32'd0);
      rd(3'd5, d); check("status_insvc", d, 32'h302);

      // complete mismatch, then matching complete with level still high
      wr(3'd4, 32'd4);
      rd(3'd5, d); check("status_mismatch", d, 32'h302);
      wr(3'd4, 32'd3);
      check("irq_after_cmp_c0", 32'(irq_out), 32'd0);
      tick();
      check("irq_after_cmp_c1", 32'(irq_out), 32'd1);
      irq_src = '0;
      repeat (6) tick();
      check("irq_idle", 32'(irq_out), 32'd0);

      // priority among simultaneous edges
      wr(3'd2, 32'hFF);
      irq_src = 8'h22; tick(); irq_src = '0;
      wait_irq("wait_prio1");
      rd(3'd3, d); check("claim_prio1", d, 32'd2);
      wr(3'd4, 32'd2);
      wait_irq("wait_prio2");
      rd(3'd3, d); check("claim_prio2", d, 32'd6);
      wr(3'd4, 32'd6);
      rd(3'd0, d); check("pending_empty", d, 32'd0);

      // edge during service
      irq_src = 8'h01; tick(); irq_src = '0;
      wait_irq("wait_edge1");
      rd(3'd3, d); check("claim_edge1", d, 32'd1);
      irq_src = 8'h01; tick(); irq_src = '0;
      repeat (4) tick();
      check("irq_insvc_low", 32'(irq_out), 32'd0);
      rd(3'd0, d); check("pending_insvc", d, 32'd1);
      wr(3'd4, 32'd1);
      check("irq_cmp_edge0", 32'(irq_out), 32'd0);
      tick();
      check("irq_cmp_edge1", 32'(irq_out), 32'd1);
      rd(3'd3, d); check("claim_edge2", d, 32'd1);
      wr(3'd4, 32'd1);

      // W1C colliding with a new edge, then plain W1C
      irq_src = 8'h04; tick(); irq_src = '0;
      wait_irq("wait_w1c");
      irq_src = 8'h04; tick(); irq_src = '0;
      tick();
      wr(3'd0, 32'h04);
      rd(3'd0, d); check("w1c_collide", d, 32'h04);
      wr(3'd0, 32'h04);
      rd(3'd0, d); check("w1c_plain", d, 32'h00);
      check("irq_after_w1c", 32'(irq_out), 32'd0);

      // unmapped / read-only offsets
      wr(3'd6, 32'hFFFF_FFFF);
      wr(3'd5, 32'hFFFF_FFFF);
      rd(3'd6, d); check("unmapped_rd", d, 32'd0);
      rd(3'd4, d); check("complete_rd", d, 32'd0);

      // randomized traffic against the model
      wr(3'd2, 32'($urandom_range(0, 255)));
      wr(3'd1, 32'hFF);
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 3) == 0) irq_src = NS'($urandom);
         case ($urandom_range(0, 9))
            4: rd(3'd3, d);
            5: wr(3'd4, ($urandom_range(0, 1) != 0) ? 32'(m_svc) : 32'($urandom_range(0, 9)));
            6: rd(3'($urandom_range(0, 7)), d);
            7: wr(3'd0, 32'($urandom));
            8: wr(3'($urandom_range(1, 2)), 32'($urandom) | 32'h0F);
            9: wr(3'($urandom_range(0, 7)), 32'($urandom));
            default: tick();
         endcase
      end

      // reset in the middle of service
      irq_src = '0;
      do_reset();
      wr(3'd1, 32'hFF);
      wr(3'd2, 32'h01);
      irq_src = 8'h01;
      wait_irq("wait_pre_rst");
      rd(3'd3, d); check("claim_pre_rst", d, 32'd1);
      rd(3'd5, d); check("status_pre_rst", d, 32'h102);
      do_reset();
      wr(3'd2, 32'h01);
      repeat (4) tick();
      rd(3'd0, d); check("pend_after_rst", d, 32'h01);
      rd(3'd1, d); check("enable_after_rst", d, 32'h00);
      wr(3'd0, 32'h01);
      rd(3'd0, d); check("pend_one_edge", d, 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
